// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: turns the synchronized write pointer into
// memory reads and presents the data first-word-fall-through through a 2-entry buffer.
module fifo_rd_ctrl #(
  parameter int ADDRESS_WIDTH   = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int ALMOST_EMPTY_TH = 2,
  parameter int SOFT_RESET      = 1
) (
  input  logic                     clk,
  input  logic                     h_rst,
  input  logic                     s_rst,
  input  logic [ADDRESS_WIDTH:0]   wr_ptr_gray_sync,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     mem_rd_en,
  output logic [ADDRESS_WIDTH-1:0] mem_rd_addr,
  output logic [ADDRESS_WIDTH:0]   rd_ptr_gray,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     empty,
  output logic                     almost_empty,
  output logic                     rd_underflow
);

  localparam int PW = ADDRESS_WIDTH + 1;
  // Wide enough for mem_count (up to 2^ADDRESS_WIDTH) plus inflight plus occ.
  localparam int CW = ADDRESS_WIDTH + 3;
  localparam logic [CW-1:0] AE_TH = CW'(ALMOST_EMPTY_TH);
  localparam bit SOFT_EN = (SOFT_RESET == 1) || (SOFT_RESET == 3);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  underflow_q, underflow_d;

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] mem_count;
  logic          mem_empty;
  logic          pop;
  logic          soft_rst;
  logic          issue;
  logic [2:0]    pending;
  logic [1:0]    occ_after_pop;
  logic [CW-1:0] level;

  assign wr_bin    = gray2bin(wr_ptr_gray_sync);
  assign mem_count = wr_bin - rd_bin_q;
  assign mem_empty = (mem_count == '0);
  assign soft_rst  = s_rst && SOFT_EN;

  assign dout_valid = (occ_q != 2'd0);
  assign pop        = dout_valid && dout_ready;

  // Words already owned by the buffer once this cycle's pop is applied.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue   = !mem_empty && (pending < 3'd2) && !h_rst;

  assign occ_after_pop = occ_q - {1'b0, pop};

  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    rd_bin_d    = rd_bin_q;
    rd_gray_d   = rd_gray_q;
    occ_d       = occ_after_pop;
    inflight_d  = issue;
    head_d      = head_q;
    skid_d      = skid_q;
    underflow_d = dout_ready && !dout_valid;

    if (issue) begin
      rd_bin_d  = rd_bin_q + PW'(1);
      rd_gray_d = bin2gray(rd_bin_q + PW'(1));
    end

    if (pop && occ_q == 2'd2) begin
      head_d = skid_q;
    end

    // The returning word lands in the first slot left free after the pop.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = mem_rdata;
      end else begin
        skid_d = mem_rdata;
      end
      occ_d = occ_after_pop + 2'd1;
    end

    if (soft_rst) begin
      rd_bin_d    = '0;
      rd_gray_d   = '0;
      occ_d       = 2'd0;
      inflight_d  = 1'b0;
      head_d      = '0;
      skid_d      = '0;
      underflow_d = 1'b0;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; the data registers are reset too because dout is visible.
  always_ff @(posedge clk or posedge h_rst) begin
    if (h_rst) begin
      rd_bin_q    <= '0;
      rd_gray_q   <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      skid_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_gray_q   <= rd_gray_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      underflow_q <= underflow_d;
    end
  end

  assign level = CW'(mem_count) + CW'(inflight_q) + CW'(occ_q);

  assign mem_rd_en    = issue;
  assign mem_rd_addr  = rd_bin_q[ADDRESS_WIDTH-1:0];
  assign rd_ptr_gray  = rd_gray_q;
  assign dout         = head_q;
  assign empty        = !dout_valid;
  assign almost_empty = (level <= AE_TH);
  assign rd_underflow = underflow_q;

`ifndef SYNTHESIS
  // The buffer can never be oversubscribed by reads already in flight.
  a_occ_bound: assert property (@(posedge clk) disable iff (h_rst)
    ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (h_rst)
    mem_rd_en |-> !mem_empty);
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a vector table for the single-word path plus scoreboarded
// streaming, backpressure, pointer wrap, hard reset and soft reset sequences.
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          clk = 1'b0;
  logic          h_rst;
  logic          s_rst;
  logic [PW-1:0] wr_gray;
  logic          dout_ready;

  logic          mem_rd_en, dout_valid, empty, almost_empty, rd_underflow;
  logic [AW-1:0] mem_rd_addr;
  logic [PW-1:0] rd_gray;
  logic [DW-1:0] dout, mem_rdata;

  logic          n_mem_rd_en, n_dout_valid, n_empty, n_almost_empty, n_rd_underflow;
  logic [AW-1:0] n_mem_rd_addr;
  logic [PW-1:0] n_rd_gray;
  logic [DW-1:0] n_dout, n_mem_rdata;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ALMOST_EMPTY_TH(2), .SOFT_RESET(1)) dut (
    .clk(clk), .h_rst(h_rst), .s_rst(s_rst), .wr_ptr_gray_sync(wr_gray),
    .mem_rdata(mem_rdata), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .rd_ptr_gray(rd_gray), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .empty(empty), .almost_empty(almost_empty), .rd_underflow(rd_underflow)
  );

  fifo_rd_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ALMOST_EMPTY_TH(2), .SOFT_RESET(0)) dut_ns (
    .clk(clk), .h_rst(h_rst), .s_rst(s_rst), .wr_ptr_gray_sync(wr_gray),
    .mem_rdata(n_mem_rdata), .mem_rd_en(n_mem_rd_en), .mem_rd_addr(n_mem_rd_addr),
    .rd_ptr_gray(n_rd_gray), .dout(n_dout), .dout_valid(n_dout_valid), .dout_ready(dout_ready),
    .empty(n_empty), .almost_empty(n_almost_empty), .rd_underflow(n_rd_underflow)
  );

  // Shared memory image, one-cycle read latency per controller.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_rd_en)   mem_rdata   <= mem[mem_rd_addr];
    if (n_mem_rd_en) n_mem_rdata <= mem[n_mem_rd_addr];
  end

  typedef struct {
    logic          add;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic [PW-1:0] e_gray;
    logic          e_ae;
    logic          e_uf;
  } vec_t;

  vec_t vecs [7];

  int            total = 0;
  int            bad   = 0;
  bit            sb_on = 1'b0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] sb_exp;
  logic [PW-1:0] wr_bin;

  logic [AW-1:0] addr_log [4];
  logic [PW-1:0] gray_log [4];
  logic [AW-1:0] exp_addr [4];
  logic [PW-1:0] exp_gray [4];

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wr_bin[AW-1:0]] = d;
    wr_bin  = wr_bin + 5'd1;
    wr_gray = to_gray(wr_bin);
    sb.push_back(d);
  endtask

  task automatic do_reset();
    h_rst      = 1'b1;
    s_rst      = 1'b0;
    dout_ready = 1'b0;
    sb_on      = 1'b0;
    wr_bin     = '0;
    wr_gray    = '0;
    sb.delete();
    step();
    step();
    h_rst = 1'b0;
    step();
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (dout_valid) break;
      step();
    end
    check(name, dout_valid, 1);
  endtask

  task automatic drain(input int budget, input string name);
    for (int k = 0; k < budget; k++) begin
      if (sb.size() == 0) break;
      step();
    end
    check(name, sb.size(), 0);
    step();
  endtask

  // Scoreboard: every accepted word must be the oldest one still owed.
  always @(negedge clk) begin
    if (sb_on && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: popped %0h, required no word", dout);
      end else begin
        sb_exp = sb.pop_front();
        check("sb_data", dout, sb_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_gray = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};

    //             add   wdata  rdy  en    addr  vld   dout   gray      ae    uf
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 4'd0, 1'b0, 8'h00, 5'b00000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b1, 8'hA5, 5'b00001, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b1, 8'hA5, 5'b00001, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 5'b00001, 1'b1, 1'b0};

    h_rst      = 1'b1;
    s_rst      = 1'b0;
    dout_ready = 1'b0;
    wr_bin     = '0;
    wr_gray    = '0;
    #2;
    check("rst_valid", dout_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_uf", rd_underflow, 0);
    check("rst_gray", rd_gray, 0);
    check("rst_dout", dout, 0);
    wr_gray = to_gray(5'd2);
    #1;
    check("rst_no_issue", mem_rd_en, 0);
    wr_gray = '0;
    step();
    step();
    h_rst = 1'b0;
    step();

    // Single word through the pipeline, then an underflow attempt.
    for (int i = 0; i < 7; i++) begin
      dout_ready = vecs[i].ready;
      if (vecs[i].add) write_word(vecs[i].wdata);
      #1;
      check($sformatf("v%0d_en", i), mem_rd_en, vecs[i].e_en);
      check($sformatf("v%0d_addr", i), mem_rd_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), dout_valid, vecs[i].e_valid);
      check($sformatf("v%0d_empty", i), empty, !vecs[i].e_valid);
      if (vecs[i].e_valid) check($sformatf("v%0d_dout", i), dout, vecs[i].e_dout);
      check($sformatf("v%0d_gray", i), rd_gray, vecs[i].e_gray);
      check($sformatf("v%0d_ae", i), almost_empty, vecs[i].e_ae);
      check($sformatf("v%0d_uf", i), rd_underflow, vecs[i].e_uf);
      step();
    end

    // Hard reset while the buffer is full.
    dout_ready = 1'b0;
    write_word(8'hB1);
    write_word(8'hB2);
    write_word(8'hB3);
    repeat (4) step();
    check("full_valid", dout_valid, 1);
    check("full_dout", dout, 8'hB1);
    check("full_ae", almost_empty, 0);
    h_rst   = 1'b1;
    wr_bin  = '0;
    wr_gray = '0;
    sb.delete();
    #1;
    check("hrst_valid", dout_valid, 0);
    check("hrst_empty", empty, 1);
    check("hrst_ae", almost_empty, 1);
    check("hrst_gray", rd_gray, 0);
    check("hrst_dout", dout, 0);
    wr_gray = to_gray(5'd2);
    #1;
    check("hrst_no_issue", mem_rd_en, 0);
    wr_gray = '0;
    step();
    step();
    h_rst = 1'b0;
    n = 0;
    repeat (5) begin
      if (mem_rd_en) n++;
      step();
    end
    check("post_rst_reads", n, 0);

    // Full-depth stream with the consumer always ready.
    do_reset();
    sb_on      = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'(i));
    #1;
    wait_valid(8, "stream_start");
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stream_valid%0d", i), dout_valid, 1);
      step();
    end
    check("stream_empty", empty, 1);
    check("stream_gray", rd_gray, 5'b11000);
    check("stream_left", sb.size(), 0);

    // Backpressure: only two words may be fetched, then a gapless drain.
    do_reset();
    sb_on = 1'b1;
    for (int i = 0; i < 16; i++) write_word(8'h80 + 8'(i));
    #1;
    n = 0;
    repeat (8) begin
      if (mem_rd_en) n++;
      step();
    end
    check("bp_reads", n, 2);
    check("bp_valid", dout_valid, 1);
    check("bp_ae", almost_empty, 0);
    check("bp_head", dout, 8'h80);
    dout_ready = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("bp_valid%0d", i), dout_valid, 1);
      step();
    end
    check("bp_empty", empty, 1);
    check("bp_left", sb.size(), 0);

    // Move both pointers to 30, then cross the 31 -> 0 wrap.
    do_reset();
    sb_on      = 1'b1;
    dout_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 15; j++) write_word(8'h20 + 8'(b * 15 + j));
      #1;
      drain(60, $sformatf("pre_wrap_drain%0d", b));
    end
    check("wrap_start_gray", rd_gray, 5'b10001);
    for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
    #1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (mem_rd_en && n < 4) begin
        addr_log[n] = mem_rd_addr;
        gray_log[n] = rd_gray;
        n++;
      end
      step();
    end
    check("wrap_reads", n, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), addr_log[i], exp_addr[i]);
      check($sformatf("wrap_gray%0d", i), gray_log[i], exp_gray[i]);
    end
    drain(10, "wrap_drain");
    check("wrap_end_gray", rd_gray, 5'b00011);

    // Soft reset while a memory word is in flight.
    do_reset();
    write_word(8'h5A);
    #1;
    step();
    s_rst = 1'b1;
    step();
    check("srst_valid", dout_valid, 0);
    check("srst_empty", empty, 1);
    check("srst_gray", rd_gray, 0);
    check("srst_ae", almost_empty, 1);
    check("srst_dout", dout, 0);
    check("nosrst_valid", n_dout_valid, 1);
    check("nosrst_dout", n_dout, 8'h5A);
    check("nosrst_gray", n_rd_gray, 5'b00001);
    step();
    check("srst_hold_valid", dout_valid, 0);
    s_rst = 1'b0;
    check("nosrst_hold_valid", n_dout_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the async FIFO with internal memory.
- Consumes the write pointer after it has been synchronized into the read domain (Gray, ADDRESS_WIDTH+1 bits).
- Sequences reads of the 1-cycle-latency dual-port memory and presents data first-word-fall-through through a 2-entry output buffer with valid/ready handshake.
- Generates the registered Gray read pointer that the write-domain synchronizer samples.

Parameters:
- ADDRESS_WIDTH, 4, memory address bits; depth = 2^ADDRESS_WIDTH; pointers are ADDRESS_WIDTH+1 bits.
- DATA_WIDTH, 8, data word width.
- ALMOST_EMPTY_TH, 2, almost_empty asserts when available words <= this value.
- SOFT_RESET, 1, s_rst honoured only when SOFT_RESET is 1 or 3; otherwise s_rst is ignored.

Ports:
- clk  input  1  read-domain clock.
- h_rst  input  1  asynchronous reset, active-high.
- s_rst  input  1  synchronous soft reset, active-high, gated by SOFT_RESET.
- wr_ptr_gray_sync  input  ADDRESS_WIDTH+1  write pointer, Gray, already synchronized to clk.
- mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en.
- mem_rd_en  output  1  memory read strobe.
- mem_rd_addr  output  ADDRESS_WIDTH  memory read address = rd_bin[ADDRESS_WIDTH-1:0].
- rd_ptr_gray  output  ADDRESS_WIDTH+1  registered Gray read pointer, toward the write domain.
- dout  output  DATA_WIDTH  head-of-FIFO word.
- dout_valid  output  1  dout holds valid data.
- dout_ready  input  1  consumer accepts dout; a pop occurs when dout_valid && dout_ready.
- empty  output  1  equals !dout_valid.
- almost_empty  output  1  low-watermark flag.
- rd_underflow  output  1  one-cycle pulse on a read attempt while empty.

Behaviour:
- Reset: h_rst high, asynchronous. Soft reset: s_rst high at a clk edge with SOFT_RESET 1/3. Both set the following:
  - rd_bin = 0, rd_ptr_gray = 0, occ = 0, inflight = 0.
  - dout = 0, dout_valid = 0, empty = 1, almost_empty = 1, rd_underflow = 0.
  - An in-flight memory word is discarded.
- wr_bin = gray2bin(wr_ptr_gray_sync), combinational.
- mem_count = (wr_bin - rd_bin) mod 2^(ADDRESS_WIDTH+1), range 0..2^ADDRESS_WIDTH. mem_empty = (mem_count == 0).
- Output buffer:
  - 2 entries: head register (drives dout) and skid register. occ is 0..2.
  - inflight = 1 in the cycle after mem_rd_en was asserted.
- Issue rule, combinational: mem_rd_en = !mem_empty && (occ + inflight - pop) < 2.
  - On issue, rd_bin increments at the clk edge, wrapping 2^(ADDRESS_WIDTH+1)-1 -> 0.
  - rd_ptr_gray = bin2gray(rd_bin), registered, so it updates the same edge rd_bin does.
- Data capture:
  - When inflight, mem_rdata is written into the first free entry after the pop is applied.
  - On a pop, skid moves to head.
  - Order is strictly preserved: head is always the oldest word.
- Throughput and latency:
  - 1 word/cycle sustained with dout_ready=1.
  - Latency from a wr_ptr_gray_sync change on an empty FIFO to dout_valid = 2 clk edges: issue at edge 1, capture at edge 2.
- Backpressure: with dout_ready=0, at most 2 words are fetched (occ + inflight <= 2), then mem_rd_en stays low.
- almost_empty = (mem_count + inflight + occ) <= ALMOST_EMPTY_TH, combinational from registers.
- rd_underflow: registered; high for one cycle after any edge where dout_ready=1 and dout_valid=0. No state change results.
- Simultaneous events:
  - pop + capture with occ=1: head takes the new word, occ stays 1.
  - pop + capture with occ=2: head takes skid, skid takes the new word.
  - s_rst has priority over every other event.
- mem_rd_en is never asserted while h_rst is high.

Test Plan:
- Apply h_rst mid-traffic with occ=2 -> all outputs immediately reach their reset values (dout_valid=0, empty=1, almost_empty=1, rd_ptr_gray=0); after release with no writes, mem_rd_en stays 0.
- Step wr_ptr_gray_sync 0 -> gray(1)=00001, mem word0=8'hA5, ready=0 -> mem_rd_en high in cycle 0, addr=0; dout=A5 and dout_valid=1 after edge 2; rd_ptr_gray=00001; almost_empty=1.
- wr_ptr_gray_sync = gray(16), ready=1, ADDRESS_WIDTH=4 -> 16 consecutive pops with dout_valid continuous, data order 0..15; rd_ptr_gray ends at gray(16)=11000; empty=1 after the last pop.
- Fill 16 words, ready=0 -> exactly 2 mem_rd_en pulses, occ=2, almost_empty=0; then ready=1 -> remaining 14 words delivered in order with no gaps.
- Start with rd_bin=wr_bin=30, write 4 words -> addresses 14, 15, 0, 1; rd_bin wraps 31 -> 0; Gray output sequence 10001, 10000, 00000, 00001.
- s_rst=1 with SOFT_RESET=1 while inflight=1 -> the in-flight word is not presented and all state is cleared next edge. Same stimulus with SOFT_RESET=0 -> no effect. ready=1 while empty -> rd_underflow one-cycle pulse.
